dsi_packet_assembler: RTL and testbench



---
 rtl/dsi_packet_assembler.sv | 174 +++++++++++++++++
 tb/tb_dsi_packet_assembler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler for one data lane: builds short/long/dummy packets with
// header ECC and payload CRC-16 and feeds them byte-wise to the lane serializer.
module dsi_packet_assembler #(
  parameter logic [15:0] CRC_INIT       = 16'hFFFF,
  parameter logic [7:0]  UNDERFLOW_FILL = 8'h00
) (
  input  logic        clk_base,
  input  logic        reset,
  input  logic        pkt_start,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic        pkt_dummy,
  input  logic        pkt_hs,
  input  logic        pkt_last,
  input  logic [7:0]  pkt_data_id,
  input  logic [15:0] pkt_wc,
  input  logic [7:0]  pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  input  logic        lane_data_request,
  output logic        lane_data_write,
  output logic [7:0]  lane_data_input,
  output logic        lane_data_type,
  output logic        lane_end_of_frame,
  output logic        lane_dummy_frame,
  output logic        busy,
  output logic        err_underflow
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_H0    = 4'd1;
  localparam logic [3:0] S_H1    = 4'd2;
  localparam logic [3:0] S_H2    = 4'd3;
  localparam logic [3:0] S_H3    = 4'd4;
  localparam logic [3:0] S_PLD   = 4'd5;
  localparam logic [3:0] S_CRC0  = 4'd6;
  localparam logic [3:0] S_CRC1  = 4'd7;
  localparam logic [3:0] S_DUMMY = 4'd8;

  logic [3:0]  state, state_nxt;
  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic        long_q, hs_q, last_q;
  logic [15:0] cnt_q;
  logic [15:0] crc_q;
  logic        err_q;
  logic        accept;
  logic [23:0] hdr;
  logic [7:0]  ecc;
  logic [7:0]  pld_byte;

  // CRC-16/CCITT, reflected polynomial, one byte LSB-first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign busy            = (state != S_IDLE);
  assign pkt_ready       = (state == S_IDLE);
  assign accept          = pkt_start & pkt_ready;
  assign lane_data_write = lane_data_request & busy;
  assign pld_ready       = lane_data_write & (state == S_PLD);
  assign lane_data_type  = hs_q & busy;
  assign err_underflow   = err_q;
  assign pld_byte        = pld_valid ? pld_data : UNDERFLOW_FILL;

  // Header ECC: 6-bit Hamming over {WC, DI}
  assign hdr    = {wc_q, di_q};
  assign ecc[0] = hdr[0]^hdr[1]^hdr[2]^hdr[4]^hdr[5]^hdr[7]^hdr[10]^hdr[11]^hdr[13]^hdr[16]^hdr[20]^hdr[21]^hdr[22]^hdr[23];
  assign ecc[1] = hdr[0]^hdr[1]^hdr[3]^hdr[4]^hdr[6]^hdr[8]^hdr[10]^hdr[12]^hdr[14]^hdr[17]^hdr[20]^hdr[21]^hdr[22]^hdr[23];
  assign ecc[2] = hdr[0]^hdr[2]^hdr[3]^hdr[5]^hdr[6]^hdr[9]^hdr[11]^hdr[12]^hdr[15]^hdr[18]^hdr[20]^hdr[21]^hdr[22];
  assign ecc[3] = hdr[1]^hdr[2]^hdr[3]^hdr[7]^hdr[8]^hdr[9]^hdr[13]^hdr[14]^hdr[15]^hdr[19]^hdr[20]^hdr[21]^hdr[23];
  assign ecc[4] = hdr[4]^hdr[5]^hdr[6]^hdr[7]^hdr[8]^hdr[9]^hdr[16]^hdr[17]^hdr[18]^hdr[19]^hdr[20]^hdr[22]^hdr[23];
  assign ecc[5] = hdr[10]^hdr[11]^hdr[12]^hdr[13]^hdr[14]^hdr[15]^hdr[16]^hdr[17]^hdr[18]^hdr[19]^hdr[21]^hdr[22]^hdr[23];
  assign ecc[7:6] = 2'b00;

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and lane byte decode; advances only on transferred bytes
  always_comb begin
    state_nxt         = state;
    lane_data_input   = 8'h00;
    lane_end_of_frame = 1'b0;
    lane_dummy_frame  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pkt_start) state_nxt = pkt_dummy ? S_DUMMY : S_H0;
      end
      S_H0: begin
        lane_data_input = di_q;
        if (lane_data_write) state_nxt = S_H1;
      end
      S_H1: begin
        lane_data_input = wc_q[7:0];
        if (lane_data_write) state_nxt = S_H2;
      end
      S_H2: begin
        lane_data_input = wc_q[15:8];
        if (lane_data_write) state_nxt = S_H3;
      end
      S_H3: begin
        lane_data_input   = ecc;
        lane_end_of_frame = last_q & ~long_q;
        if (lane_data_write) begin
          if (!long_q)             state_nxt = S_IDLE;
          else if (wc_q != 16'd0)  state_nxt = S_PLD;
          else                     state_nxt = S_CRC0;
        end
      end
      S_PLD: begin
        lane_data_input = pld_byte;
        if (lane_data_write && cnt_q == 16'd1) state_nxt = S_CRC0;
      end
      S_CRC0: begin
        lane_data_input = crc_q[7:0];
        if (lane_data_write) state_nxt = S_CRC1;
      end
      S_CRC1: begin
        lane_data_input   = crc_q[15:8];
        lane_end_of_frame = last_q;
        if (lane_data_write) state_nxt = S_IDLE;
      end
      S_DUMMY: begin
        lane_dummy_frame  = 1'b1;
        lane_end_of_frame = 1'b1;
        if (lane_data_write) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, payload counter, CRC and underflow flag
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      di_q   <= 8'h00;
      wc_q   <= 16'h0000;
      long_q <= 1'b0;
      hs_q   <= 1'b0;
      last_q <= 1'b0;
      cnt_q  <= 16'h0000;
      crc_q  <= 16'h0000;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        di_q   <= pkt_data_id;
        wc_q   <= pkt_wc;
        long_q <= pkt_long & ~pkt_dummy;
        hs_q   <= pkt_hs;
        last_q <= pkt_last;
        err_q  <= 1'b0;
      end
      if (lane_data_write) begin
        if (state == S_H3 && long_q) begin
          crc_q <= CRC_INIT;
          cnt_q <= wc_q;
        end
        if (state == S_PLD) begin
          crc_q <= crc16_byte(crc_q, pld_byte);
          cnt_q <= cnt_q - 16'd1;
          if (!pld_valid) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Scoreboard bench for dsi_packet_assembler: expected lane bytes are queued
// when a request is issued and compared as the lane accepts them.
module tb_dsi_packet_assembler;

  typedef struct packed {
    logic [7:0] data;
    logic       hs;
    logic       eof;
    logic       dmy;
  } lane_exp_t;

  logic        clk_base = 1'b0;
  logic        reset;
  logic        pkt_start, pkt_ready, pkt_long, pkt_dummy, pkt_hs, pkt_last;
  logic [7:0]  pkt_data_id;
  logic [15:0] pkt_wc;
  logic [7:0]  pld_data;
  logic        pld_valid, pld_ready;
  logic        lane_data_request, lane_data_write;
  logic [7:0]  lane_data_input;
  logic        lane_data_type, lane_end_of_frame, lane_dummy_frame;
  logic        busy, err_underflow;

  int n_chk  = 0;
  int n_pass = 0;

  lane_exp_t  exp_q[$];
  logic [7:0] pld_b[16];
  bit         pld_v[16];
  int         pld_n    = 0;
  int         pld_slot = 0;
  bit         pld_take = 0;
  int         pld_cnt  = 0;
  int         req_mode = 0;

  dsi_packet_assembler dut (
    .clk_base(clk_base), .reset(reset),
    .pkt_start(pkt_start), .pkt_ready(pkt_ready), .pkt_long(pkt_long),
    .pkt_dummy(pkt_dummy), .pkt_hs(pkt_hs), .pkt_last(pkt_last),
    .pkt_data_id(pkt_data_id), .pkt_wc(pkt_wc),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .lane_data_request(lane_data_request), .lane_data_write(lane_data_write),
    .lane_data_input(lane_data_input), .lane_data_type(lane_data_type),
    .lane_end_of_frame(lane_end_of_frame), .lane_dummy_frame(lane_dummy_frame),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk_base = ~clk_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [7:0] model_ecc(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [23:0] masks[6];
    logic [7:0]  e;
    masks = '{24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
    d = {wc, di};
    e = 8'h00;
    for (int i = 0; i < 6; i++) e[i] = ^(d & masks[i]);
    return e;
  endfunction

  function automatic logic [15:0] model_crc(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  // Lane request pattern: held high, toggling, or random
  initial begin
    lane_data_request = 1'b0;
    forever begin
      @(posedge clk_base); #1;
      case (req_mode)
        0:       lane_data_request = 1'b1;
        1:       lane_data_request = ~lane_data_request;
        default: lane_data_request = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Payload source: one slot per consumed byte
  initial begin
    pld_valid = 1'b0;
    pld_data  = 8'h00;
    forever begin
      @(posedge clk_base);
      if (pld_take) pld_slot++;
      #1;
      pld_valid = (pld_slot < pld_n) ? pld_v[pld_slot] : 1'b0;
      pld_data  = (pld_slot < pld_n) ? pld_b[pld_slot] : 8'hEE;
    end
  end

  // Monitor: compare every transferred byte against the scoreboard
  always @(negedge clk_base) begin
    lane_exp_t e;
    if (lane_data_write) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(lane_data_input), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("lane_byte", 32'({lane_data_input, lane_data_type, lane_end_of_frame, lane_dummy_frame}), 32'(e));
      end
    end
    if (pld_ready) begin
      pld_cnt++;
      check("pld_ready_align", 32'(lane_data_write), 32'd1);
    end
    pld_take = pld_ready;
  end

  task automatic push(input logic [7:0] d, input bit hs, input bit eof, input bit dmy);
    lane_exp_t e;
    e = '{data: d, hs: hs, eof: eof, dmy: dmy};
    exp_q.push_back(e);
  endtask

  task automatic send(input bit lng, input bit dmy, input bit hs, input bit last,
                      input logic [7:0] di, input logic [15:0] wc, input bit model);
    logic [15:0] crc;
    logic [7:0]  b;
    if (model) begin
      if (dmy) push(8'h00, hs, 1'b1, 1'b1);
      else begin
        push(di, hs, 1'b0, 1'b0);
        push(wc[7:0], hs, 1'b0, 1'b0);
        push(wc[15:8], hs, 1'b0, 1'b0);
        push(model_ecc(di, wc), hs, last & ~lng, 1'b0);
        if (lng) begin
          crc = 16'hFFFF;
          for (int i = 0; i < int'(wc); i++) begin
            b   = pld_v[i] ? pld_b[i] : 8'h00;
            crc = model_crc(crc, b);
            push(b, hs, 1'b0, 1'b0);
          end
          push(crc[7:0], hs, 1'b0, 1'b0);
          push(crc[15:8], hs, last, 1'b0);
        end
      end
    end
    @(posedge clk_base); #1;
    pkt_start = 1'b1; pkt_long = lng; pkt_dummy = dmy; pkt_hs = hs; pkt_last = last;
    pkt_data_id = di; pkt_wc = wc;
    @(posedge clk_base); #1;
    pkt_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_base);
      if (busy) busy_cyc++;
      else if (exp_q.size() == 0) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_pld(input int n, input logic [7:0] base, input int hole);
    pld_n = n;
    for (int i = 0; i < 16; i++) begin
      pld_b[i] = base + 8'(i);
      pld_v[i] = (i != hole);
    end
    pld_slot = 0;
  endtask

  initial begin
    int cyc, p0;
    reset = 1'b1;
    pkt_start = 1'b0; pkt_long = 1'b0; pkt_dummy = 1'b0; pkt_hs = 1'b0; pkt_last = 1'b0;
    pkt_data_id = 8'h00; pkt_wc = 16'h0000;
    #23;
    check("rst_pkt_ready", 32'(pkt_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write", 32'(lane_data_write), 32'd0);
    check("rst_outputs", 32'({lane_data_input, lane_data_type, lane_end_of_frame, lane_dummy_frame}), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    @(posedge clk_base); #1 reset = 1'b0;

    // Short HS packet with known ECC, request held high
    req_mode = 0;
    push(8'h05, 1'b1, 1'b0, 1'b0);
    push(8'h11, 1'b1, 1'b0, 1'b0);
    push(8'h00, 1'b1, 1'b0, 1'b0);
    push(8'h36, 1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 16'h0011, 1'b0);
    wait_idle(50, cyc);
    check("short_busy_cycles", 32'(cyc), 32'd4);

    // Long packet with zero word count: CRC is the seed
    send(1'b1, 1'b0, 1'b1, 1'b1, 8'h39, 16'h0000, 1'b1);
    wait_idle(50, cyc);
    check("wc0_busy_cycles", 32'(cyc), 32'd6);

    // Long WC=3, toggling request
    req_mode = 1;
    load_pld(3, 8'h01, -1);
    p0 = pld_cnt;
    send(1'b1, 1'b0, 1'b0, 1'b1, 8'h29, 16'h0003, 1'b1);
    wait_idle(100, cyc);
    check("pld_pulses", 32'(pld_cnt - p0), 32'd3);
    check("no_underflow", 32'(err_underflow), 32'd0);

    // Same packet with a missing second payload byte
    load_pld(3, 8'h01, 1);
    send(1'b1, 1'b0, 1'b0, 1'b1, 8'h29, 16'h0003, 1'b1);
    wait_idle(100, cyc);
    check("underflow_set", 32'(err_underflow), 32'd1);
    repeat (3) @(negedge clk_base);
    check("underflow_sticky", 32'(err_underflow), 32'd1);

    // Dummy overrides long; also clears the sticky underflow
    req_mode = 0;
    send(1'b1, 1'b1, 1'b1, 1'b0, 8'h39, 16'h0010, 1'b1);
    @(negedge clk_base);
    check("dummy_ready_low", 32'(pkt_ready), 32'd0);
    check("underflow_cleared", 32'(err_underflow), 32'd0);
    @(negedge clk_base);
    check("dummy_ready_back", 32'(pkt_ready), 32'd1);
    wait_idle(20, cyc);

    // Random request stalls on a longer packet
    req_mode = 2;
    load_pld(5, 8'hA0, -1);
    send(1'b1, 1'b0, 1'b1, 1'b0, 8'h79, 16'h0005, 1'b1);
    wait_idle(300, cyc);

    // Reset in the middle of a WC=8 payload
    req_mode = 0;
    load_pld(8, 8'h40, -1);
    p0 = pld_cnt;
    send(1'b1, 1'b0, 1'b1, 1'b1, 8'h39, 16'h0008, 1'b1);
    for (int i = 0; i < 50 && (pld_cnt - p0) < 3; i++) @(negedge clk_base);
    check("reached_payload", 32'(pld_cnt - p0 >= 3), 32'd1);
    @(posedge clk_base); #1;
    reset = 1'b1;
    #1;
    check("abort_write", 32'(lane_data_write), 32'd0);
    check("abort_ready", 32'(pkt_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pld_n = 0;
    @(posedge clk_base); #1 reset = 1'b0;
    send(1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 16'hABCD, 1'b1);
    wait_idle(50, cyc);
    check("post_reset_busy_cycles", 32'(cyc), 32'd4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
